raw2rgb_bin: RTL

- Parametrised successor to the current Bayer-to-RGB stage in the camera_controller pipeline.
- Converts a RAW Bayer stream into one RGB pixel per 2x2 quad (2x2 binning), so output resolution is half in each axis.
- Adds selectable Bayer orientation, selectable green mode, output width reduction, quad coordinates and sticky error flags.
- Buffers the even row in an internal paired-word RAM. Sits between the sensor capture and the downstream RGB/grey consumers.

---
 rtl/raw2rgb_bin.sv | 106 ++++++++++
 1 files changed

// File: rtl/raw2rgb_bin.sv
// raw2rgb_bin: 2x2-binning Bayer RAW to RGB converter, one RGB pixel per quad.
// Ports: iCLK/iRST clock and sync active-high reset; iPATTERN Bayer orientation
// (latched at frame origin); iX_Cont/iY_Cont/iDATA/iDVAL RAW sample stream;
// oRed/oGreen/oBlue/oDVAL/oX_Cont/oY_Cont quad result; oERR sticky
// {unpaired odd-column sample, column overflow}.
module raw2rgb_bin #(
  parameter int DATA_W     = 12,
  parameter int OUT_W      = 12,
  parameter int MAX_COLS   = 2048,
  parameter int CNT_W      = 11,
  parameter int GREEN_MODE = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [1:0]        iPATTERN,
  input  logic [CNT_W-1:0]  iX_Cont,
  input  logic [CNT_W-1:0]  iY_Cont,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  output logic [OUT_W-1:0]  oRed,
  output logic [OUT_W-1:0]  oGreen,
  output logic [OUT_W-1:0]  oBlue,
  output logic              oDVAL,
  output logic [CNT_W-1:0]  oX_Cont,
  output logic [CNT_W-1:0]  oY_Cont,
  output logic [1:0]        oERR
);
  localparam int AW = (MAX_COLS > 2) ? $clog2(MAX_COLS / 2) : 1;
  logic [2*DATA_W-1:0] mem_q [MAX_COLS/2];
  logic [2*DATA_W-1:0] rd_q;
  logic [DATA_W-1:0]   he_q, le_q;
  logic                pe_q, po_q, pe_d, po_d, dval_q;
  logic [1:0]          pat_q, err_q;
  logic [OUT_W-1:0]    red_q, grn_q, blu_q;
  logic [CNT_W-1:0]    ox_q, oy_q;
  logic                ovf, smp, odd_r, odd_c, wr_en, rd_en, out_en, unp;
  logic [AW-1:0]       addr;
  logic [DATA_W-1:0]   tl, tr, bl, br, r, b, ge, go, g;
  logic [DATA_W:0]     gsum;
  always_comb begin
    ovf    = iDVAL && ({1'b0, iX_Cont} >= (CNT_W+1)'(MAX_COLS));
    smp    = iDVAL && !ovf;
    odd_r  = iY_Cont[0];
    odd_c  = iX_Cont[0];
    addr   = AW'(iX_Cont >> 1);
    wr_en  = smp && !odd_r && odd_c && pe_q;
    rd_en  = smp && odd_r && !odd_c;
    out_en = smp && odd_r && odd_c && po_q;
    unp    = smp && odd_c && (odd_r ? !po_q : !pe_q);
    // Every in-range sample rewrites both pair flags: only an even-column sample
    // of the matching row parity can leave one set, which also covers row changes.
    pe_d   = smp ? (!odd_r && !odd_c) : pe_q;
    po_d   = smp ? (odd_r && !odd_c) : po_q;
    tl     = rd_q[2*DATA_W-1:DATA_W];
    tr     = rd_q[DATA_W-1:0];
    bl     = le_q;
    br     = iDATA;
    // pat_q[1] selects the row holding red, pat_q[0] its column; blue is diagonal.
    r      = pat_q[1] ? (pat_q[0] ? br : bl) : (pat_q[0] ? tr : tl);
    b      = pat_q[1] ? (pat_q[0] ? tl : tr) : (pat_q[0] ? bl : br);
    ge     = (pat_q[0] ^ pat_q[1]) ? tl : tr;
    go     = (pat_q[0] ^ pat_q[1]) ? br : bl;
    gsum   = {1'b0, ge} + {1'b0, go};
    g      = (GREEN_MODE != 0) ? ge : DATA_W'(gsum >> 1);
  end
  always_ff @(posedge iCLK) begin
    if (wr_en) mem_q[addr] <= {he_q, iDATA};
    if (rd_en) rd_q <= mem_q[addr];
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pe_q   <= 1'b0;
      po_q   <= 1'b0;
      pat_q  <= 2'd3;
      err_q  <= 2'b00;
      dval_q <= 1'b0;
      red_q  <= '0;
      grn_q  <= '0;
      blu_q  <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
    end else begin
      pe_q   <= pe_d;
      po_q   <= po_d;
      dval_q <= out_en;
      err_q  <= err_q | {unp, ovf};
      if (smp && iX_Cont == '0 && iY_Cont == '0) pat_q <= iPATTERN;
      if (smp && !odd_r && !odd_c) he_q <= iDATA;
      if (smp && odd_r && !odd_c) le_q <= iDATA;
      if (out_en) begin
        red_q <= r[DATA_W-1 -: OUT_W];
        grn_q <= g[DATA_W-1 -: OUT_W];
        blu_q <= b[DATA_W-1 -: OUT_W];
        ox_q  <= iX_Cont >> 1;
        oy_q  <= iY_Cont >> 1;
      end
    end
  end
  assign oRed    = red_q;
  assign oGreen  = grn_q;
  assign oBlue   = blu_q;
  assign oDVAL   = dval_q;
  assign oX_Cont = ox_q;
  assign oY_Cont = oy_q;
  assign oERR    = err_q;
endmodule
